// File: rtl/lift_pkg.sv
// Shared types and default timing for the lift stop sequencer: controller states,
// travel-direction encoding and the sizing helper for the door timer.
package lift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_OPENING = 3'd2,
    ST_DWELL   = 3'd3,
    ST_CLOSING = 3'd4
  } lift_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } lift_dir_e;

  localparam int DEF_N_FLOORS         = 8;
  localparam int DEF_DOOR_MOVE_CYCLES = 4;
  localparam int DEF_DWELL_CYCLES     = 8;

  // The door timer holds the larger of the two durations minus one, so size for max+1.
  function automatic int timer_width(input int door_cycles, input int dwell_cycles);
    int longest;
    longest = (door_cycles > dwell_cycles) ? door_cycles : dwell_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/lift_stop_sequencer_if.sv
// Scheduler <-> stop sequencer signal bundle. The scheduler side is the master;
// the sequencer is the slave.
interface lift_stop_sequencer_if
  import lift_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS
);

  logic                i_motion;
  logic                i_direction;
  logic                i_has_rqst_at_stopped_flr;
  logic [N_FLOORS-1:0] i_flr_pos;
  logic                i_door_hold;

  logic                o_motor_en;
  logic                o_motor_dir;
  logic                o_door_opening;
  logic                o_door_closing;
  logic                o_door_is_open;
  logic                o_up_clr;
  logic                o_dn_clr;
  logic                o_flr_clr;
  logic                o_busy;

  modport master (
    output i_motion, i_direction, i_has_rqst_at_stopped_flr, i_flr_pos, i_door_hold,
    input  o_motor_en, o_motor_dir, o_door_opening, o_door_closing, o_door_is_open,
           o_up_clr, o_dn_clr, o_flr_clr, o_busy
  );

  modport slave (
    input  i_motion, i_direction, i_has_rqst_at_stopped_flr, i_flr_pos, i_door_hold,
    output o_motor_en, o_motor_dir, o_door_opening, o_door_closing, o_door_is_open,
           o_up_clr, o_dn_clr, o_flr_clr, o_busy
  );

endinterface

// File: rtl/lift_dwell_timer.sv
// Loadable down-counter shared by the door phases; expired is high while the count
// sits at zero, i.e. during the last cycle of the phase that loaded it.
module lift_dwell_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/lift_stop_sequencer.sv
// Stop sequencer for one lift car: runs the motor while the scheduler asks for
// motion, then cycles the door open/dwell/close at the floor it stops on.
module lift_stop_sequencer
  import lift_pkg::*;
#(
  parameter int N_FLOORS         = DEF_N_FLOORS,
  parameter int DOOR_MOVE_CYCLES = DEF_DOOR_MOVE_CYCLES,
  parameter int DWELL_CYCLES     = DEF_DWELL_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  lift_stop_sequencer_if.slave bus
);

  localparam int TW = timer_width(DOOR_MOVE_CYCLES, DWELL_CYCLES);

  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  // A hold restarts the dwell with the hold cycle itself counted as its first cycle.
  localparam logic [TW-1:0] HOLD_LOAD  = TW'((DWELL_CYCLES > 1) ? DWELL_CYCLES - 2 : 0);

  lift_state_e   state_q;
  lift_state_e   state_d;

  logic          at_floor;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_tick;
  logic          tmr_expired;
  logic          clr_d;

  logic          motor_en_q;
  logic          motor_dir_q;
  logic          door_opening_q;
  logic          door_closing_q;
  logic          door_is_open_q;
  logic          up_clr_q;
  logic          dn_clr_q;
  logic          flr_clr_q;
  logic          busy_q;

  assign at_floor = |bus.i_flr_pos[N_FLOORS-1:0];

  lift_dwell_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .expired  (tmr_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_tick     = 1'b0;
    clr_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_motion) begin
          state_d = ST_MOVE;
        end else if (bus.i_has_rqst_at_stopped_flr && at_floor) begin
          state_d      = ST_OPENING;
          tmr_load     = 1'b1;
          tmr_load_val = DOOR_LOAD;
          clr_d        = 1'b1;
        end
      end

      ST_MOVE: begin
        // Between floors the car keeps moving even if the scheduler drops motion.
        if (at_floor && !bus.i_motion) begin
          if (bus.i_has_rqst_at_stopped_flr) begin
            state_d      = ST_OPENING;
            tmr_load     = 1'b1;
            tmr_load_val = DOOR_LOAD;
            clr_d        = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_OPENING: begin
        if (tmr_expired) begin
          state_d      = ST_DWELL;
          tmr_load     = 1'b1;
          tmr_load_val = DWELL_LOAD;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      ST_DWELL: begin
        if (bus.i_door_hold) begin
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end else if (tmr_expired) begin
          state_d      = ST_CLOSING;
          tmr_load     = 1'b1;
          tmr_load_val = DOOR_LOAD;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      ST_CLOSING: begin
        // Reopening for an obstruction serves no new request, so no clear pulses.
        if (bus.i_door_hold) begin
          state_d      = ST_OPENING;
          tmr_load     = 1'b1;
          tmr_load_val = DOOR_LOAD;
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      motor_en_q     <= 1'b0;
      motor_dir_q    <= DIR_UP;
      door_opening_q <= 1'b0;
      door_closing_q <= 1'b0;
      door_is_open_q <= 1'b0;
      up_clr_q       <= 1'b0;
      dn_clr_q       <= 1'b0;
      flr_clr_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      motor_en_q     <= (state_d == ST_MOVE);
      door_opening_q <= (state_d == ST_OPENING);
      door_closing_q <= (state_d == ST_CLOSING);
      door_is_open_q <= (state_d == ST_DWELL);
      up_clr_q       <= clr_d && (lift_dir_e'(bus.i_direction) == DIR_UP);
      dn_clr_q       <= clr_d && (lift_dir_e'(bus.i_direction) == DIR_DN);
      flr_clr_q      <= clr_d;
      busy_q         <= (state_d != ST_IDLE);
      if ((state_q != ST_MOVE) && (state_d == ST_MOVE)) begin
        motor_dir_q <= bus.i_direction;
      end
    end
  end

  assign bus.o_motor_en     = motor_en_q;
  assign bus.o_motor_dir    = motor_dir_q;
  assign bus.o_door_opening = door_opening_q;
  assign bus.o_door_closing = door_closing_q;
  assign bus.o_door_is_open = door_is_open_q;
  assign bus.o_up_clr       = up_clr_q;
  assign bus.o_dn_clr       = dn_clr_q;
  assign bus.o_flr_clr      = flr_clr_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_lift_stop_sequencer.sv
// Directed bench for the lift stop sequencer: reset, door cycle timing, holds,
// motion priority and direction latching, with hand-computed expectations.
module tb_lift_stop_sequencer;
  import lift_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  lift_stop_sequencer_if #(.N_FLOORS(8)) bus ();

  lift_stop_sequencer #(
    .N_FLOORS         (8),
    .DOOR_MOVE_CYCLES (4),
    .DWELL_CYCLES     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int up_total    = 0;
  int dn_total    = 0;
  int flr_total   = 0;

  // Running totals of clear pulses; tests compare deltas against a snapshot.
  always @(negedge clk) begin
    if (bus.o_up_clr)  up_total++;
    if (bus.o_dn_clr)  dn_total++;
    if (bus.o_flr_clr) flr_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit order: motor_en, motor_dir, opening, closing, is_open, up_clr, dn_clr, flr_clr, busy
  function automatic logic [8:0] outs();
    return {bus.o_motor_en, bus.o_motor_dir, bus.o_door_opening, bus.o_door_closing,
            bus.o_door_is_open, bus.o_up_clr, bus.o_dn_clr, bus.o_flr_clr, bus.o_busy};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic door_sig(input int sel);
    case (sel)
      0:       return bus.o_door_opening;
      1:       return bus.o_door_is_open;
      default: return bus.o_door_closing;
    endcase
  endfunction

  // Counts consecutive cycles (current one included) that the selected door output is high.
  task automatic run_len(input int sel, output int n);
    n = 0;
    while (door_sig(sel) && n < 64) begin
      n++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int up0, dn0, flr0;

    bus.i_motion                 = 1'b0;
    bus.i_direction              = 1'b0;
    bus.i_has_rqst_at_stopped_flr = 1'b0;
    bus.i_flr_pos                = 8'b0;
    bus.i_door_hold              = 1'b0;

    #12;
    check("reset_outs", outs(), 9'b000000000);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("idle_after_reset", outs(), 9'b000000000);

    // Door cycle from IDLE, travelling up.
    up0 = up_total; dn0 = dn_total; flr0 = flr_total;
    bus.i_flr_pos                 = 8'b0000_0100;
    bus.i_has_rqst_at_stopped_flr = 1'b1;
    bus.i_direction               = 1'b0;
    step();
    check("idle_to_opening", outs(), 9'b001001011);
    bus.i_has_rqst_at_stopped_flr = 1'b0;
    run_len(0, n);
    check("opening_len", n, 4);
    run_len(1, n);
    check("dwell_len", n, 8);
    run_len(2, n);
    check("closing_len", n, 4);
    check("back_to_idle", outs(), 9'b000000000);
    check("up_clr_count", up_total - up0, 1);
    check("dn_clr_count", dn_total - dn0, 0);
    check("flr_clr_count", flr_total - flr0, 1);

    // Motion wins over a pending request at the current floor.
    bus.i_motion                  = 1'b1;
    bus.i_has_rqst_at_stopped_flr = 1'b1;
    bus.i_direction               = 1'b1;
    step();
    check("motion_priority", outs(), 9'b110000001);

    // Between floors the car stays in MOVE; direction changes are ignored.
    up0 = up_total; dn0 = dn_total; flr0 = flr_total;
    bus.i_flr_pos                 = 8'b0;
    bus.i_motion                  = 1'b0;
    bus.i_has_rqst_at_stopped_flr = 1'b0;
    bus.i_direction               = 1'b0;
    step(); step(); step();
    check("move_between_floors", outs(), 9'b110000001);

    bus.i_flr_pos                 = 8'b0001_0000;
    bus.i_has_rqst_at_stopped_flr = 1'b1;
    bus.i_direction               = 1'b1;
    step();
    check("move_to_opening", outs(), 9'b011000111);
    bus.i_has_rqst_at_stopped_flr = 1'b0;
    run_len(0, n);
    check("opening_len_2", n, 4);

    // Hold during the 6th dwell cycle.
    n = 0;
    while (bus.o_door_is_open && n < 64) begin
      n++;
      bus.i_door_hold = (n == 6);
      step();
    end
    bus.i_door_hold = 1'b0;
    check("dwell_hold_len", n, 13);
    check("closing_first", outs(), 9'b010100001);

    // Hold during the 2nd closing cycle reopens without clear pulses.
    step();
    bus.i_door_hold = 1'b1;
    step();
    bus.i_door_hold = 1'b0;
    check("closing_reopen", outs(), 9'b011000001);
    run_len(0, n);
    check("reopen_len", n, 4);
    run_len(1, n);
    check("dwell_full_len", n, 8);
    run_len(2, n);
    check("closing_len_2", n, 4);
    check("idle_dir_held", outs(), 9'b010000000);
    check("up_clr_count_2", up_total - up0, 0);
    check("dn_clr_count_2", dn_total - dn0, 1);
    check("flr_clr_count_2", flr_total - flr0, 1);

    // Asynchronous reset in the middle of a move.
    bus.i_motion    = 1'b1;
    bus.i_direction = 1'b0;
    step();
    check("move_before_reset", outs(), 9'b100000001);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outs", outs(), 9'b000000000);
    bus.i_motion = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("idle_after_rerelease", outs(), 9'b000000000);
    bus.i_flr_pos                 = 8'b0000_0001;
    bus.i_has_rqst_at_stopped_flr = 1'b1;
    bus.i_direction               = 1'b1;
    step();
    check("first_transition", outs(), 9'b001000111);
    bus.i_has_rqst_at_stopped_flr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lift_stop_sequencer.md
LIFT_STOP_SEQUENCER -- requirements
Module: lift_stop_sequencer

Interface
REQ-001 Parameter N_FLOORS, default 8, number of floors; width of i_flr_pos.
REQ-002 Parameter DOOR_MOVE_CYCLES, default 4, door opening/closing travel time in clk cycles (>=1).
REQ-003 Parameter DWELL_CYCLES, default 8, door fully-open dwell time in clk cycles (>=1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 i_motion  input  1  scheduler requests car movement.
REQ-007 i_direction  input  1  scheduler direction; 0 = up, 1 = down.
REQ-008 i_has_rqst_at_stopped_flr  input  1  a request is pending at the floor where the car is stopped.
REQ-009 i_flr_pos  input  N_FLOORS  one-hot floor sensor; all-zero means the car is between floors.
REQ-010 i_door_hold  input  1  door obstruction or door-open button.
REQ-011 o_motor_en  output  1  motor drive enable.
REQ-012 o_motor_dir  output  1  motor direction, latched; 0 = up, 1 = down.
REQ-013 o_door_opening / o_door_closing / o_door_is_open  output  1 each  door actuator commands and status.
REQ-014 o_up_clr / o_dn_clr / o_flr_clr  output  1 each  one-cycle request-clear pulses for the current floor.
REQ-015 o_busy  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL implement five states: IDLE, MOVE, OPENING, DWELL, CLOSING.
REQ-017 IDLE SHALL exit as follows, with i_motion taking priority: if i_motion=1, go to MOVE; else if i_has_rqst_at_stopped_flr=1 and |i_flr_pos=1, go to OPENING.
REQ-018 MOVE SHALL return to IDLE when i_motion=0, |i_flr_pos=1 and i_has_rqst_at_stopped_flr=0.
REQ-019 MOVE SHALL go to OPENING when i_motion=0, |i_flr_pos=1 and i_has_rqst_at_stopped_flr=1.
REQ-020 While i_flr_pos=0, MOVE SHALL remain in MOVE regardless of i_motion.
REQ-021 o_motor_dir SHALL be loaded from i_direction on entry to MOVE and held for the rest of that MOVE.
REQ-022 All outputs SHALL be registered.
REQ-023 o_motor_en SHALL be 1 exactly while in MOVE; door outputs SHALL be 0 in MOVE and IDLE.
REQ-024 The motor SHALL never be enabled unless the door is closed, because MOVE is reachable only from IDLE.
REQ-025 On every transition into OPENING from IDLE or MOVE, exactly one clear pulse set SHALL be issued, in the first OPENING cycle:
- o_flr_clr=1;
- o_up_clr=1 if i_direction=0;
- o_dn_clr=1 if i_direction=1.
REQ-026 OPENING SHALL assert o_door_opening for DOOR_MOVE_CYCLES cycles, then go to DWELL.
REQ-027 DWELL SHALL assert o_door_is_open for DWELL_CYCLES cycles, then go to CLOSING; i_door_hold=1 SHALL reload the dwell count.
REQ-028 CLOSING SHALL assert o_door_closing for DOOR_MOVE_CYCLES cycles, then go to IDLE.
REQ-029 i_door_hold=1 in CLOSING SHALL go to OPENING next cycle with a reloaded count and without clear pulses.
REQ-030 A single down-counter of width $clog2(max(DOOR_MOVE_CYCLES,DWELL_CYCLES)+1) SHALL be:
- loaded with (duration-1) on state entry;
- used to trigger the state exit when it reaches 0.
REQ-031 i_motion and i_direction SHALL be ignored in OPENING, DWELL and CLOSING.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, counter=0 and every output to 0, including mid-MOVE or mid-door operation.
REQ-033 After reset deassertion, the first transition SHALL occur on the next rising clk edge per REQ-017.

Structure
REQ-034 The state enum, direction encodings (UP=0, DN=1) and default timing constants SHALL reside in the shared package lift_pkg.
REQ-035 The down-counter SHALL be a sub-module, lift_dwell_timer, with inputs load, load_val and tick, and output expired.

Verification
REQ-036 Reset low mid-MOVE (o_motor_en=1) -> all outputs 0 in the same cycle; state is IDLE after release.
REQ-037 IDLE, i_flr_pos=8'b0000_0100, i_has_rqst_at_stopped_flr=1, i_direction=0 ->
- o_flr_clr and o_up_clr pulse once, o_dn_clr stays 0;
- o_door_opening for 4 cycles, o_door_is_open for 8 cycles, o_door_closing for 4 cycles;
- then IDLE.
REQ-038 MOVE with i_direction=1 latched, i_motion dropped while i_flr_pos=0 -> stays in MOVE.
REQ-039 Same run, i_flr_pos=8'b0001_0000, request pending -> OPENING with o_dn_clr pulse.
REQ-040 i_door_hold=1 on the 6th DWELL cycle -> dwell extended to 13 cycles total.
REQ-041 i_door_hold=1 on the 2nd CLOSING cycle -> next cycle is OPENING with no clear pulses, then a full 8-cycle DWELL.
REQ-042 Simultaneous i_motion=1 and i_has_rqst_at_stopped_flr=1 in IDLE -> MOVE, no door activity.
